odd_even_sorter: RTL and testbench
==================================

ODD_EVEN_SORTER -- requirements
Module: odd_even_sorter

Interface
REQ-001 Parameter DATA_W, default 32: element width in bits.
REQ-002 Parameter DEPTH, default 8, legal range 2..64: elements per sort job.
REQ-003 Parameter SIGNED, default 0: 0 compares as unsigned, 1 compares as two's-complement.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 descend  input  1  order select, captured with start: 0 ascending, 1 descending.
REQ-008 data_in  input  DEPTH*DATA_W  flat element bus; element k occupies bits [k*DATA_W +: DATA_W].
REQ-009 data_out  output  DEPTH*DATA_W  sorted result, same packing; holds its value until the next job completes.
REQ-010 busy  output  1  high while a job is in progress (SORT state).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 passes  output  $clog2(DEPTH+1)  phases executed by the last job; holds until the next job completes.

Function
REQ-013 FSM has three states: IDLE, SORT and DONE.
REQ-014 IDLE: on an edge with start=1, capture data_in into the working array, capture descend, set the phase counter to 0, set the parity to even, and go to SORT.
REQ-015 Start when not in IDLE: ignored, with no queuing; this includes start during DONE.
REQ-016 Phase behaviour: each SORT edge executes one compare-exchange phase on the working array.
REQ-017 Even phase compares pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),...; parity toggles every phase, starting even.
REQ-018 Swap rule: a pair (k,k+1) swaps iff element k > element k+1 (ascending), or element k < element k+1 (descending). Equal elements never swap.
REQ-019 All pairs in one phase are evaluated in parallel from the pre-phase array.
REQ-020 Each phase increments the phase counter and records whether any swap occurred.
REQ-021 Early termination: leave SORT after the phase in which either (a) that phase and the preceding phase both made no swap, or (b) the phase counter reaches DEPTH.
REQ-022 Leaving SORT, same edge: load data_out with the post-phase array, load passes with the phase count, go to DONE.
REQ-023 DONE: done=1 for exactly that one cycle; the next edge returns to IDLE.
REQ-024 Latency: if start is accepted at edge E0, done is high in the cycle after edge E0+P, where P = passes and 2 <= P <= DEPTH.
REQ-025 busy=1 exactly in SORT; busy=0 in IDLE and DONE.
REQ-026 DEPTH=2: the odd phase has no pairs and never swaps.
REQ-027 Odd DEPTH: the last element is unpaired in even phases; even DEPTH: the last element is unpaired in odd phases.
REQ-028 Result: data_out is a permutation of the captured input, ordered per descend.
REQ-029 Repeated-element multiplicities are preserved.

Reset
REQ-030 On an edge with rst=1: state=IDLE, busy=0, done=0, data_out=0, passes=0, working array and counters cleared.
REQ-031 rst takes priority over start.
REQ-032 Reset during SORT or DONE aborts the job with no done pulse.
REQ-033 The first start after reset deasserts is accepted normally.

Verification (DEPTH=8, DATA_W=32 unless stated)
REQ-034 Sorted input {0,1,...,7}, descend=0 -> passes=2, done 2 cycles after the accept edge, data_out={0..7}.
REQ-035 Reversed input {7,...,0}, descend=0 -> passes=8, data_out={0..7}, busy high for exactly 8 cycles.
REQ-036 Input {3,1,2,2,9,0,5,5}, descend=1 -> data_out={9,5,5,3,2,2,1,0}.
REQ-037 SIGNED=1, input {5,0xFFFFFFFF,0,...}, descend=0 -> element 0 = 0xFFFFFFFF. The same input with SIGNED=0 -> element 7 = 0xFFFFFFFF.
REQ-038 start pulsed at phase 3 and during DONE -> both ignored; exactly one done pulse; data_out matches the first job.
REQ-039 rst=1 at phase 4 of a reversed-input job -> next cycle busy=0, done=0, data_out=0, passes=0; no done pulse follows. A new start then completes normally.

Source files
------------

// File: rtl/odd_even_sorter.sv
// Odd-even transposition sorter: one compare-exchange phase per clock, with
// early exit once two consecutive phases leave the array untouched.
module odd_even_sorter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          descend,
  input  logic [DEPTH*DATA_W-1:0]       data_in,
  output logic [DEPTH*DATA_W-1:0]       data_out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DEPTH+1)-1:0]    passes
);

  localparam int PW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] arr     [DEPTH];
  logic [DATA_W-1:0] arr_nxt [DEPTH];
  logic              desc_q;
  logic              odd_q;
  logic              prev_swap;
  logic [PW-1:0]     phase_cnt;
  logic [PW-1:0]     phase_nxt;
  logic              any_swap;
  logic              finish;

  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Pairs of one parity never overlap, so every swap reads the pre-phase array.
  always_comb begin
    arr_nxt  = arr;
    any_swap = 1'b0;
    for (int k = 0; k < DEPTH-1; k++) begin
      if ((k % 2) == (odd_q ? 1 : 0)) begin
        if (desc_q ? gt(arr[k+1], arr[k]) : gt(arr[k], arr[k+1])) begin
          arr_nxt[k]   = arr[k+1];
          arr_nxt[k+1] = arr[k];
          any_swap     = 1'b1;
        end
      end
    end
    phase_nxt = phase_cnt + PW'(1);
    finish    = (!any_swap && !prev_swap) || (phase_nxt == PW'(DEPTH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SORT;
      SORT:    if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SORT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) arr[k] <= '0;
      desc_q    <= 1'b0;
      odd_q     <= 1'b0;
      prev_swap <= 1'b0;
      phase_cnt <= '0;
      data_out  <= '0;
      passes    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < DEPTH; k++) arr[k] <= data_in[k*DATA_W +: DATA_W];
            desc_q    <= descend;
            phase_cnt <= '0;
            odd_q     <= 1'b0;
            // No phase precedes the first, so treat it as having swapped.
            prev_swap <= 1'b1;
          end
        end
        SORT: begin
          for (int k = 0; k < DEPTH; k++) arr[k] <= arr_nxt[k];
          phase_cnt <= phase_nxt;
          odd_q     <= ~odd_q;
          prev_swap <= any_swap;
          if (finish) begin
            for (int k = 0; k < DEPTH; k++) data_out[k*DATA_W +: DATA_W] <= arr_nxt[k];
            passes <= phase_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Bench for odd_even_sorter: unsigned and signed instances share stimulus and
// are compared each cycle against a job-level reference model.
module tb_odd_even_sorter;
  localparam int FW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          descend = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic [FW-1:0] dout    [2];
  logic          busy_v  [2];
  logic          done_v  [2];
  logic [3:0]    pass_v  [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  odd_even_sorter #(.DATA_W(32), .DEPTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .descend(descend), .data_in(data_in),
    .data_out(dout[0]), .busy(busy_v[0]), .done(done_v[0]), .passes(pass_v[0]));

  odd_even_sorter #(.DATA_W(32), .DEPTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .descend(descend), .data_in(data_in),
    .data_out(dout[1]), .busy(busy_v[1]), .done(done_v[1]), .passes(pass_v[1]));

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] pk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    return sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  function automatic bit wrong_order(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit dsc);
    return dsc ? gt(b, a, sgn) : gt(a, b, sgn);
  endfunction

  // Expected result: an ordinary insertion sort of the captured elements.
  function automatic logic [FW-1:0] ref_sort(input logic [FW-1:0] f, input bit sgn, input bit dsc);
    logic [31:0] v [8];
    logic [31:0] key;
    logic [FW-1:0] r;
    int j;
    for (int i = 0; i < 8; i++) v[i] = f[i*32 +: 32];
    for (int i = 1; i < 8; i++) begin
      key = v[i];
      j = i - 1;
      while (j >= 0 && wrong_order(v[j], key, sgn, dsc)) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = key;
    end
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i];
    return r;
  endfunction

  // Expected phase count: run transposition phases until two quiet phases or the cap.
  function automatic int ref_passes(input logic [FW-1:0] f, input bit sgn, input bit dsc);
    logic [31:0] v [8];
    logic [31:0] n [8];
    bit sw, prev_sw;
    for (int i = 0; i < 8; i++) v[i] = f[i*32 +: 32];
    prev_sw = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      sw = 1'b0;
      n = v;
      for (int k = (p - 1) % 2; k < 7; k += 2)
        if (wrong_order(v[k], v[k+1], sgn, dsc)) begin
          n[k] = v[k+1]; n[k+1] = v[k]; sw = 1'b1;
        end
      v = n;
      if (!sw && !prev_sw) return p;
      prev_sw = sw;
    end
    return 8;
  endfunction

  bit            m_busy [2];
  bit            m_done [2];
  logic [FW-1:0] m_out  [2];
  logic [FW-1:0] m_exp  [2];
  int            m_left [2];
  int            m_p    [2];
  int            m_pass [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_out[i] = '0; m_left[i] = 0; m_pass[i] = 0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_busy[i] = 0; m_done[i] = 1; m_out[i] = m_exp[i]; m_pass[i] = m_p[i];
        end
      end else if (start) begin
        m_p[i]    = ref_passes(data_in, bit'(i), descend);
        m_exp[i]  = ref_sort(data_in, bit'(i), descend);
        m_left[i] = m_p[i];
        m_busy[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), FW'(busy_v[i]), FW'(m_busy[i]));
        chk($sformatf("done%0d", i), FW'(done_v[i]), FW'(m_done[i]));
        chk($sformatf("data_out%0d", i), dout[i], m_out[i]);
        chk($sformatf("passes%0d", i), FW'(pass_v[i]), FW'(m_pass[i]));
      end
    end
  end

  task automatic run_job(input logic [FW-1:0] d, input bit dsc, output int bc, output int dc);
    @(negedge clk);
    data_in = d; descend = dsc; start = 1'b1;
    bc = 0; dc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (busy_v[0]) bc++;
      if (done_v[0]) dc++;
    end
    chk("job_idle", FW'(busy_v[0] | busy_v[1]), FW'(0));
  endtask

  logic [FW-1:0] v_sorted, v_rev, v_dup, v_sgn, v_mix, v_same;
  int bc, dc;

  initial begin
    v_sorted = pk8(0, 1, 2, 3, 4, 5, 6, 7);
    v_rev    = pk8(7, 6, 5, 4, 3, 2, 1, 0);
    v_dup    = pk8(3, 1, 2, 2, 9, 0, 5, 5);
    v_sgn    = pk8(5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    v_mix    = pk8(32'h8000_0000, 4, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 4, 1, 0, 32'h8000_0000);
    v_same   = pk8(7, 7, 7, 7, 7, 7, 7, 7);

    chk("model_p_sorted", FW'(ref_passes(v_sorted, 0, 0)), FW'(2));
    chk("model_p_rev", FW'(ref_passes(v_rev, 0, 0)), FW'(8));
    chk("model_sort_dup", ref_sort(v_dup, 0, 1), pk8(9, 5, 5, 3, 2, 2, 1, 0));

    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", FW'(busy_v[0]), FW'(0));
    chk("rst_dout", dout[0], '0);
    @(negedge clk);
    rst = 1'b0;

    run_job(v_sorted, 0, bc, dc);
    chk("sorted_busy_cycles", FW'(bc), FW'(2));
    chk("sorted_done_count", FW'(dc), FW'(1));
    chk("sorted_passes", FW'(pass_v[0]), FW'(2));
    chk("sorted_dout", dout[0], v_sorted);

    run_job(v_rev, 0, bc, dc);
    chk("rev_busy_cycles", FW'(bc), FW'(8));
    chk("rev_passes", FW'(pass_v[0]), FW'(8));
    chk("rev_dout", dout[0], v_sorted);

    run_job(v_dup, 1, bc, dc);
    chk("dup_desc_dout", dout[0], pk8(9, 5, 5, 3, 2, 2, 1, 0));
    chk("dup_done_count", FW'(dc), FW'(1));

    run_job(v_sgn, 0, bc, dc);
    chk("signed_elem0", FW'(dout[1][31:0]), FW'(32'hFFFF_FFFF));
    chk("unsigned_elem7", FW'(dout[0][255:224]), FW'(32'hFFFF_FFFF));

    run_job(v_mix, 1, bc, dc);
    run_job(v_mix, 0, bc, dc);
    run_job(v_same, 1, bc, dc);
    chk("same_passes", FW'(pass_v[0]), FW'(2));

    // Starts mid-sort and during DONE must both be dropped.
    @(negedge clk);
    data_in = v_rev; descend = 1'b0; start = 1'b1;
    dc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 2) begin start = 1'b1; data_in = v_dup; end
      else if (start) start = 1'b0;
      if (done_v[0]) begin
        dc++;
        if (dc == 1) start = 1'b1;
      end
    end
    chk("ignore_done_count", FW'(dc), FW'(1));
    chk("ignore_dout", dout[0], v_sorted);

    // Reset in the middle of a job aborts it without a done pulse.
    @(negedge clk);
    data_in = v_rev; descend = 1'b0; start = 1'b1;
    dc = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        chk("abort_busy", FW'(busy_v[0]), FW'(0));
        chk("abort_done", FW'(done_v[0]), FW'(0));
        chk("abort_dout", dout[0], '0);
        chk("abort_passes", FW'(pass_v[0]), FW'(0));
      end
      if (done_v[0]) dc++;
    end
    chk("abort_no_done", FW'(dc), FW'(0));

    run_job(v_dup, 0, bc, dc);
    chk("after_abort_dout", dout[0], pk8(0, 1, 2, 2, 3, 5, 5, 9));
    chk("after_abort_done", FW'(dc), FW'(1));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
